key_encoder_4_2: RTL and testbench



---
 rtl/key_enc_pkg.sv | 37 +++
 rtl/key_encoder_4_2_if.sv | 28 ++
 rtl/key_debounce.sv | 72 +++++++
 rtl/key_encoder_4_2.sv | 60 ++++++
 tb/tb_key_encoder_4_2.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/key_enc_pkg.sv
// Shared types, reset constants and encode helpers for the 4-key priority encoder.
// Key 0 has the highest priority.
package key_enc_pkg;

    localparam int unsigned NUM_KEYS = 4;

    typedef enum logic [1:0] {
        StReleased       = 2'b00,
        StPressPending   = 2'b01,
        StPressed        = 2'b10,
        StReleasePending = 2'b11
    } key_state_t;

    localparam logic       KEY_RST_SYNC = 1'b1;
    localparam logic [1:0] CODE_RST     = 2'b00;

    // Lowest set index wins; an empty vector returns the held code unchanged.
    function automatic logic [1:0] prio_enc(input logic [NUM_KEYS-1:0] db,
                                            input logic [1:0]          hold);
        logic [1:0] idx;
        idx = hold;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (db[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic two_or_more(input logic [NUM_KEYS-1:0] db);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n += 32'(db[i]);
        end
        return n >= 2;
    endfunction

endpackage

// File: rtl/key_encoder_4_2_if.sv
// Key pins in, encoded key events out. The encoder takes the slave side;
// whatever owns the pins and consumes the events takes the master side.
interface key_encoder_4_2_if;
    import key_enc_pkg::*;

    logic [NUM_KEYS-1:0] key_n;
    logic [1:0]          code;
    logic                valid;
    logic                press_stb;
    logic                multi;

    modport master (
        output key_n,
        input  code,
        input  valid,
        input  press_stb,
        input  multi
    );

    modport slave (
        input  key_n,
        output code,
        output valid,
        output press_stb,
        output multi
    );

endinterface

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, then a four-state debounce FSM with a stability counter.
// The debounced level is the top bit of the registered state.
module key_debounce
    import key_enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic db
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    key_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s;

    assign s  = ~sync_q[1];
    assign db = state_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {2{KEY_RST_SYNC}};
            state_q <= StReleased;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            unique case (state_q)
                StReleased: begin
                    if (s) begin
                        cnt_q   <= '0;
                        state_q <= StPressPending;
                    end
                end
                StPressPending: begin
                    // Any bounce back restarts the count from the stable state.
                    if (!s) begin
                        cnt_q   <= '0;
                        state_q <= StReleased;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        state_q <= StPressed;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!s) begin
                        cnt_q   <= '0;
                        state_q <= StReleasePending;
                    end
                end
                StReleasePending: begin
                    if (s) begin
                        cnt_q   <= '0;
                        state_q <= StPressed;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        state_q <= StReleased;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/key_encoder_4_2.sv
// Four debounced active-low keys into a registered 2-bit priority code with valid,
// multi-key flag and a one-cycle strobe whenever a new code is accepted.
module key_encoder_4_2
    import key_enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input logic               clk,
    input logic               rst_n,
    key_encoder_4_2_if.slave  bus
);

    logic [NUM_KEYS-1:0] db;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .key_n (bus.key_n[i]),
            .db    (db[i])
        );
    end

    logic [1:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       stb_q, stb_d;
    logic       multi_q, multi_d;

    always_comb begin
        valid_d = |db;
        multi_d = two_or_more(db);
        code_d  = prio_enc(db, code_q);
        // Strobe on a fresh press or whenever the winning key changes while held.
        stb_d   = valid_d && (!valid_q || (code_d != code_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= CODE_RST;
            valid_q <= 1'b0;
            stb_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
            stb_q   <= stb_d;
            multi_q <= multi_d;
        end
    end

    assign bus.code      = code_q;
    assign bus.valid     = valid_q;
    assign bus.press_stb = stb_q;
    assign bus.multi     = multi_q;

endmodule

// File: tb/tb_key_encoder_4_2.sv
// Directed bench for key_encoder_4_2 with a 4-cycle debounce window.
`timescale 1ns/1ps
module tb_key_encoder_4_2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   stb_cnt;

    key_encoder_4_2_if bus ();

    key_encoder_4_2 #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge and tally any strobe seen there.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.press_stb === 1'b1) stb_cnt++;
    endtask

    // Called right after the edge at which new key levels were driven; the change is
    // first sampled at the following edge N, so outputs must move exactly at N+7.
    task automatic wait_accept(input string tag, input logic prev_valid, input logic exp_valid,
                               input logic [1:0] exp_code, input logic exp_multi,
                               input logic exp_stb);
        int c0;
        c0 = stb_cnt;
        repeat (7) tick();
        check({tag, "_early_stb"}, 32'(stb_cnt - c0), 32'd0);
        check({tag, "_early_valid"}, 32'(bus.valid), 32'(prev_valid));
        tick();
        check({tag, "_valid"}, 32'(bus.valid), 32'(exp_valid));
        check({tag, "_code"}, 32'(bus.code), 32'(exp_code));
        check({tag, "_multi"}, 32'(bus.multi), 32'(exp_multi));
        check({tag, "_stb"}, 32'(bus.press_stb), 32'(exp_stb));
        tick();
        check({tag, "_stb_one_cycle"}, 32'(bus.press_stb), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_code"}, 32'(bus.code), 32'd0);
        check({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check({tag, "_stb"}, 32'(bus.press_stb), 32'd0);
        check({tag, "_multi"}, 32'(bus.multi), 32'd0);
    endtask

    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
    endtask

    initial begin
        int c0;
        checks    = 0;
        failures  = 0;
        stb_cnt   = 0;
        rst_n     = 1'b1;
        bus.key_n = 4'hF;
        #2 rst_n = 1'b0;
        #20;
        check_idle_outputs("rst_init");

        // Key 2 accepted, then reset mid-cycle must clear the outputs at once.
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.key_n = 4'b1011;
        wait_accept("k2_first", 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        async_reset_pulse();
        check_idle_outputs("rst_async");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        async_reset_pulse();
        check_idle_outputs("rst_midcount");
        tick();
        rst_n = 1'b1;
        wait_accept("k2_after_rst", 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        bus.key_n = 4'hF;
        wait_accept("k2_release", 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);

        // Clean press of key 1 held 20 cycles.
        c0 = stb_cnt;
        bus.key_n = 4'b1101;
        wait_accept("k1_press", 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        repeat (11) tick();
        check("k1_one_stb", 32'(stb_cnt - c0), 32'd1);
        bus.key_n = 4'hF;
        wait_accept("k1_release", 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);

        // Key 3 bounces with 3-cycle low/high phases, then settles low.
        c0 = stb_cnt;
        for (int p = 0; p < 5; p++) begin
            bus.key_n = 4'b0111;
            repeat (3) tick();
            bus.key_n = 4'hF;
            repeat (3) tick();
        end
        check("bounce_no_stb", 32'(stb_cnt - c0), 32'd0);
        check("bounce_valid", 32'(bus.valid), 32'd0);
        check("bounce_code", 32'(bus.code), 32'd1);
        bus.key_n = 4'b0111;
        wait_accept("k3_settled", 1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        check("k3_one_stb", 32'(stb_cnt - c0), 32'd1);
        bus.key_n = 4'hF;
        wait_accept("k3_release", 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);

        // Priority: key 0 over a held key 2, then back.
        bus.key_n = 4'b1011;
        wait_accept("prio_k2", 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        bus.key_n = 4'b1010;
        wait_accept("prio_k0", 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
        bus.key_n = 4'b1011;
        wait_accept("prio_k0_rel", 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
        bus.key_n = 4'hF;
        wait_accept("prio_all_rel", 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);

        // Keys 1 and 3 on the same edge.
        c0 = stb_cnt;
        bus.key_n = 4'b0101;
        wait_accept("simul", 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
        repeat (5) tick();
        check("simul_one_stb", 32'(stb_cnt - c0), 32'd1);
        bus.key_n = 4'hF;
        wait_accept("simul_rel", 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);

        // Short glitch on key 0, then a clean press must still take the full window.
        c0 = stb_cnt;
        bus.key_n = 4'b1110;
        repeat (3) tick();
        bus.key_n = 4'hF;
        repeat (12) tick();
        check("glitch_no_stb", 32'(stb_cnt - c0), 32'd0);
        check("glitch_valid", 32'(bus.valid), 32'd0);
        check("glitch_code", 32'(bus.code), 32'd1);
        bus.key_n = 4'b1110;
        wait_accept("k0_after_glitch", 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        bus.key_n = 4'hF;
        wait_accept("k0_release", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
